// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a five-stage in-order pipeline.
// It produces the pipeline register load enables, the bubble (flush)
// controls, the EX-stage operand forwarding selects, two saturating
// performance counters and a sticky data-memory timeout flag.
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   reset           in   asynchronous active-low reset
//   id_Rn, id_Rm    in   ID-stage source registers
//   id_uses_*       in   ID instruction reads Rn / Rm / flags
//   ex_Rn, ex_Rm    in   EX-stage source registers (forwarding compare)
//   ex_Rd           in   EX-stage destination
//   ex_MemRead      in   EX instruction is a load
//   ex_RegWrite     in   EX instruction writes a register (not needed here)
//   ex_FlagWrite    in   EX instruction writes the flags
//   ex_branch_taken in   taken branch resolved in EX
//   mem_Rd/RegWrite in   MEM-stage destination and write enable
//   wb_Rd/RegWrite  in   WB-stage destination and write enable
//   mem_req/mem_ack in   data-memory request (held until ack) / acknowledge
//   cnt_clr         in   synchronous clear of counters and mem_timeout
//   *_en            out  pipeline register load enables
//   ifid/idex_flush out  load a bubble into the register
//   fwdA, fwdB      out  operand select: 00 regfile, 10 MEM, 01 WB
//   stall_cnt       out  cycles with pc_en low (saturating)
//   flush_cnt       out  cycles of taken-branch flush (saturating)
//   mem_timeout     out  sticky: memory wait reached TIMEOUT cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_Rn,
    input  logic [4:0]  id_Rm,
    input  logic        id_uses_Rn,
    input  logic        id_uses_Rm,
    input  logic        id_uses_flags,
    input  logic [4:0]  ex_Rn,
    input  logic [4:0]  ex_Rm,
    input  logic [4:0]  ex_Rd,
    input  logic        ex_MemRead,
    input  logic        ex_RegWrite,
    input  logic        ex_FlagWrite,
    input  logic        ex_branch_taken,
    input  logic [4:0]  mem_Rd,
    input  logic        mem_RegWrite,
    input  logic [4:0]  wb_Rd,
    input  logic        wb_RegWrite,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        cnt_clr,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        mem_timeout
);

    localparam logic [4:0]  XZR         = 5'd31;
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        freeze;
    logic        load_use;
    logic        flag_haz;
    logic        hazard;
    logic [15:0] wait_cnt;
    logic [15:0] wait_inc;

    // Results of EX instructions that only write registers reach their
    // consumers through forwarding, so the EX write enable is not needed.
    logic unused_inputs;
    assign unused_inputs = ex_RegWrite;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // MEM has the younger result, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       m_we,
                                           input logic [4:0] m_rd,
                                           input logic       w_we,
                                           input logic [4:0] w_rd);
        if (m_we && (m_rd != XZR) && (m_rd == src))
            return 2'b10;
        else if (w_we && (w_rd != XZR) && (w_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Freeze is independent of the FSM state: an outstanding request that
    // is not yet acknowledged holds the whole pipe.
    assign freeze   = mem_req & ~mem_ack;
    assign load_use = ex_MemRead && (ex_Rd != XZR) &&
                      ((id_uses_Rn && (id_Rn == ex_Rd)) ||
                       (id_uses_Rm && (id_Rm == ex_Rd)));
    assign flag_haz = ex_FlagWrite & id_uses_flags;
    assign hazard   = load_use | flag_haz;
    assign wait_inc = sat_inc(wait_cnt);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (freeze)  state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ack) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    // Output logic: priority freeze > branch > hazard > normal flow
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fwdA       = 2'b00;
        fwdB       = 2'b00;
        if (reset) begin
            fwdA = fwd_sel(ex_Rn, mem_RegWrite, mem_Rd, wb_RegWrite, wb_Rd);
            fwdB = fwd_sel(ex_Rm, mem_RegWrite, mem_Rd, wb_RegWrite, wb_Rd);
            if (!freeze) begin
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                if (ex_branch_taken) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed.
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (hazard) begin
                    // Hold PC and IF/ID, send a bubble down into EX.
                    idex_flush = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
        end
    end

    // Performance counters; clear has priority over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else if (cnt_clr) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (!pc_en)
                stall_cnt <= sat_inc(stall_cnt);
            if (ifid_flush)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

    // Memory wait watchdog. The count restarts on every entry to MEM_WAIT
    // and the flag sets on the cycle the count lands on TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            if (state == RUN) begin
                if (freeze)
                    wait_cnt <= 16'd0;
            end else begin
                wait_cnt <= wait_inc;
            end

            if (cnt_clr)
                mem_timeout <= 1'b0;
            else if ((state == MEM_WAIT) && (wait_inc == TIMEOUT_VAL))
                mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_Rn, id_Rm, ex_Rn, ex_Rm, ex_Rd, mem_Rd, wb_Rd;
    logic        id_uses_Rn, id_uses_Rm, id_uses_flags;
    logic        ex_MemRead, ex_RegWrite, ex_FlagWrite, ex_branch_taken;
    logic        mem_RegWrite, wb_RegWrite, mem_req, mem_ack, cnt_clr;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] stall_cnt, flush_cnt;
    logic        mem_timeout;
    logic [6:0]  ctl;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_waiting;
    int m_wait, m_stall, m_flush;
    bit m_to;

    typedef enum {ACT_OFF, ACT_FREEZE, ACT_BRANCH, ACT_STALL, ACT_RUN} act_t;

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

    pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .id_Rn(id_Rn), .id_Rm(id_Rm),
        .id_uses_Rn(id_uses_Rn), .id_uses_Rm(id_uses_Rm), .id_uses_flags(id_uses_flags),
        .ex_Rn(ex_Rn), .ex_Rm(ex_Rm), .ex_Rd(ex_Rd),
        .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_FlagWrite(ex_FlagWrite),
        .ex_branch_taken(ex_branch_taken),
        .mem_Rd(mem_Rd), .mem_RegWrite(mem_RegWrite),
        .wb_Rd(wb_Rd), .wb_RegWrite(wb_RegWrite),
        .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwdA(fwdA), .fwdB(fwdB),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    // ---------------- reference model ----------------
    function automatic act_t exp_action();
        bit hz;
        if (!reset) return ACT_OFF;
        if (mem_req && !mem_ack) return ACT_FREEZE;
        if (ex_branch_taken) return ACT_BRANCH;
        hz = ex_FlagWrite && id_uses_flags;
        if (ex_MemRead && ex_Rd != 5'd31) begin
            if (id_uses_Rn && id_Rn == ex_Rd) hz = 1;
            if (id_uses_Rm && id_Rm == ex_Rd) hz = 1;
        end
        return hz ? ACT_STALL : ACT_RUN;
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    function automatic logic [6:0] exp_ctl(act_t a);
        case (a)
            ACT_BRANCH: return 7'b11111_11;
            ACT_STALL:  return 7'b00111_01;
            ACT_RUN:    return 7'b11111_00;
            default:    return 7'b00000_00;
        endcase
    endfunction

    function automatic logic [1:0] exp_fwd(logic [4:0] src);
        if (!reset) return 2'b00;
        if (mem_RegWrite && mem_Rd != 5'd31 && mem_Rd == src) return 2'b10;
        if (wb_RegWrite && wb_Rd != 5'd31 && wb_Rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_clear();
        m_waiting = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0;
    endtask

    // Advance one clock edge and step the model with the inputs seen at it.
    task automatic tick();
        act_t a;
        a = exp_action();
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            if (cnt_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (a == ACT_FREEZE || a == ACT_STALL) m_stall = sat(m_stall + 1);
                if (a == ACT_BRANCH) m_flush = sat(m_flush + 1);
            end
            if (m_waiting) begin
                m_wait = sat(m_wait + 1);
                if (m_wait == int'(TO)) m_to = 1;
                if (mem_ack) m_waiting = 0;
            end else if (mem_req && !mem_ack) begin
                m_waiting = 1;
                m_wait = 0;
            end
            if (cnt_clr) m_to = 0;
        end
        #1;
    endtask

    task automatic set_idle();
        id_Rn = 5'd31; id_Rm = 5'd31; ex_Rn = 5'd31; ex_Rm = 5'd31;
        ex_Rd = 5'd31; mem_Rd = 5'd31; wb_Rd = 5'd31;
        id_uses_Rn = 0; id_uses_Rm = 0; id_uses_flags = 0;
        ex_MemRead = 0; ex_RegWrite = 0; ex_FlagWrite = 0; ex_branch_taken = 0;
        mem_RegWrite = 0; wb_RegWrite = 0; mem_req = 0; mem_ack = 0; cnt_clr = 0;
    endtask

    task automatic clear_counters();
        set_idle();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        mem_req = 1; ex_branch_taken = 1;
        mem_RegWrite = 1; mem_Rd = 5'd5; ex_Rn = 5'd5; ex_Rm = 5'd5;
        reset = 0;
        model_clear();
        #1;
        n_checks++;
        if (ctl !== 7'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000000", ctl); end
        n_checks++;
        if ({fwdA, fwdB} !== 4'b0) begin n_fail++; $display("FAIL reset_fwd: got %b%b want 0000", fwdA, fwdB); end
        tick(); tick();
        n_checks++;
        if ({stall_cnt, flush_cnt} !== 32'd0 || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: stall %0d flush %0d to %b want 0 0 0", stall_cnt, flush_cnt, mem_timeout);
        end
        set_idle();
        reset = 1;
        #1;
        n_checks++;
        if (ctl !== 7'b11111_00) begin n_fail++; $display("FAIL reset_release_ctl: got %b want 1111100", ctl); end
    endtask

    task automatic test_load_use();
        clear_counters();
        ex_MemRead = 1; ex_Rd = 5'd2; id_uses_Rn = 1; id_Rn = 5'd2;
        #1;
        n_checks++;
        if (ctl !== 7'b00111_01) begin n_fail++; $display("FAIL load_use_ctl: got %b want 0011101", ctl); end
        tick();
        n_checks++;
        if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt); end
        set_idle();
        #1;
        n_checks++;
        if (ctl !== 7'b11111_00) begin n_fail++; $display("FAIL load_use_release: got %b want 1111100", ctl); end
        ex_MemRead = 1; ex_Rd = 5'd31; id_uses_Rn = 1; id_Rn = 5'd31; id_uses_Rm = 1; id_Rm = 5'd31;
        #1;
        n_checks++;
        if (ctl !== 7'b11111_00) begin n_fail++; $display("FAIL load_use_xzr: got %b want 1111100", ctl); end
        set_idle();
        ex_MemRead = 1; ex_Rd = 5'd7; id_uses_Rm = 1; id_Rm = 5'd7;
        #1;
        n_checks++;
        if (ctl !== 7'b00111_01) begin n_fail++; $display("FAIL load_use_rm: got %b want 0011101", ctl); end
        id_uses_Rm = 0;
        #1;
        n_checks++;
        if (ctl !== 7'b11111_00) begin n_fail++; $display("FAIL load_use_rm_unused: got %b want 1111100", ctl); end
        set_idle();
        ex_FlagWrite = 1; id_uses_flags = 1;
        #1;
        n_checks++;
        if (ctl !== 7'b00111_01) begin n_fail++; $display("FAIL flag_hazard: got %b want 0011101", ctl); end
        tick();
        n_checks++;
        if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL flag_stall_cnt: got %0d want 2", stall_cnt); end
        set_idle();
    endtask

    task automatic test_mem_wait();
        clear_counters();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl !== 7'b0) begin n_fail++; $display("FAIL mem_wait_freeze%0d: got %b want 0000000", i, ctl); end
            tick();
        end
        mem_ack = 1;
        #1;
        n_checks++;
        if (ctl !== 7'b11111_00) begin n_fail++; $display("FAIL mem_wait_ack: got %b want 1111100", ctl); end
        tick();
        set_idle();
        n_checks++;
        if (stall_cnt !== 16'd3 || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_cnt: stall %0d to %b want 3 0", stall_cnt, mem_timeout);
        end
        tick();
    endtask

    task automatic test_branch();
        clear_counters();
        ex_branch_taken = 1; ex_MemRead = 1; ex_Rd = 5'd4; id_uses_Rn = 1; id_Rn = 5'd4;
        #1;
        n_checks++;
        if (ctl !== 7'b11111_11) begin n_fail++; $display("FAIL branch_ctl: got %b want 1111111", ctl); end
        tick();
        n_checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL branch_cnt: flush %0d stall %0d want 1 0", flush_cnt, stall_cnt);
        end
        mem_req = 1;
        #1;
        n_checks++;
        if (ctl !== 7'b0) begin n_fail++; $display("FAIL branch_frozen: got %b want 0000000", ctl); end
        tick();
        mem_ack = 1;
        #1;
        n_checks++;
        if (ctl !== 7'b11111_11) begin n_fail++; $display("FAIL branch_on_ack: got %b want 1111111", ctl); end
        tick();
        n_checks++;
        if (flush_cnt !== 16'd2 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL branch_ack_cnt: flush %0d stall %0d want 2 1", flush_cnt, stall_cnt);
        end
        set_idle();
        tick();
    endtask

    task automatic test_forwarding();
        set_idle();
        ex_Rn = 5'd5; mem_Rd = 5'd5; wb_Rd = 5'd5; mem_RegWrite = 1; wb_RegWrite = 1;
        #1;
        n_checks++;
        if (fwdA !== 2'b10) begin n_fail++; $display("FAIL fwd_mem_prio: got %b want 10", fwdA); end
        mem_RegWrite = 0;
        #1;
        n_checks++;
        if (fwdA !== 2'b01) begin n_fail++; $display("FAIL fwd_wb: got %b want 01", fwdA); end
        wb_RegWrite = 0;
        #1;
        n_checks++;
        if (fwdA !== 2'b00) begin n_fail++; $display("FAIL fwd_none: got %b want 00", fwdA); end
        ex_Rm = 5'd31; mem_Rd = 5'd31; wb_Rd = 5'd31; mem_RegWrite = 1; wb_RegWrite = 1;
        #1;
        n_checks++;
        if (fwdB !== 2'b00) begin n_fail++; $display("FAIL fwd_xzr: got %b want 00", fwdB); end
        ex_Rm = 5'd9; wb_Rd = 5'd9;
        #1;
        n_checks++;
        if (fwdB !== 2'b01 || fwdA !== 2'b00) begin n_fail++; $display("FAIL fwdB_wb: got %b/%b want 00/01", fwdA, fwdB); end
        set_idle();
    endtask

    task automatic test_timeout();
        clear_counters();
        mem_req = 1;
        tick();                       // RUN -> MEM_WAIT
        tick(); tick(); tick();       // three MEM_WAIT cycles
        n_checks++;
        if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", mem_timeout); end
        tick();                       // fourth MEM_WAIT cycle
        n_checks++;
        if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b want 1", mem_timeout); end
        mem_ack = 1;
        tick();
        set_idle();
        tick();
        n_checks++;
        if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout); end
        // Clear in the same cycle as a stall increment.
        ex_MemRead = 1; ex_Rd = 5'd3; id_uses_Rn = 1; id_Rn = 5'd3; cnt_clr = 1;
        tick();
        n_checks++;
        if (mem_timeout !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL clear_wins: to %b stall %0d want 0 0", mem_timeout, stall_cnt);
        end
        set_idle();
    endtask

    task automatic test_reset_mid_wait();
        clear_counters();
        mem_req = 1;
        tick(); tick();
        reset = 0;                    // asserted between edges
        model_clear();
        #1;
        n_checks++;
        if (ctl !== 7'b0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_wait: ctl %b stall %0d want 0000000 0", ctl, stall_cnt);
        end
        tick();
        set_idle();
        reset = 1;
        tick(); tick();
        mem_req = 1;
        tick(); tick(); tick(); tick();
        n_checks++;
        if (mem_timeout !== 1'b0 || stall_cnt !== 16'd4) begin
            n_fail++; $display("FAIL wait_after_reset: to %b stall %0d want 0 4", mem_timeout, stall_cnt);
        end
        mem_ack = 1;
        tick();
        set_idle();
    endtask

    function automatic logic [4:0] rreg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    task automatic test_random();
        bit pending;
        pending = 0;
        for (int i = 0; i < 600; i++) begin
            id_Rn = rreg(); id_Rm = rreg(); ex_Rn = rreg(); ex_Rm = rreg();
            ex_Rd = rreg(); mem_Rd = rreg(); wb_Rd = rreg();
            id_uses_Rn = 1'($urandom); id_uses_Rm = 1'($urandom); id_uses_flags = 1'($urandom);
            ex_MemRead = 1'($urandom); ex_RegWrite = 1'($urandom);
            ex_FlagWrite = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_RegWrite = 1'($urandom); wb_RegWrite = 1'($urandom);
            cnt_clr = ($urandom_range(0, 40) == 0);
            if (!pending) pending = ($urandom_range(0, 4) == 0);
            mem_req = pending;
            mem_ack = pending && ($urandom_range(0, 3) == 0);
            if (mem_ack) pending = 0;
            reset = ($urandom_range(0, 99) != 0);
            if (!reset) begin
                model_clear();
                pending = 0;
            end
            #1;
            n_checks++;
            if (ctl !== exp_ctl(exp_action())) begin
                n_fail++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, ctl, exp_ctl(exp_action()));
            end
            n_checks++;
            if (fwdA !== exp_fwd(ex_Rn) || fwdB !== exp_fwd(ex_Rm)) begin
                n_fail++; $display("FAIL rand_fwd[%0d]: got %b/%b want %b/%b", i, fwdA, fwdB, exp_fwd(ex_Rn), exp_fwd(ex_Rm));
            end
            tick();
            n_checks++;
            if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) || mem_timeout !== m_to) begin
                n_fail++; $display("FAIL rand_state[%0d]: stall %0d flush %0d to %b want %0d %0d %b",
                                   i, stall_cnt, flush_cnt, mem_timeout, m_stall, m_flush, m_to);
            end
        end
        reset = 1;
        set_idle();
    endtask

    initial begin
        set_idle();
        reset = 0;
        model_clear();
        #2;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_forwarding();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, MEM_WAIT cycles before mem_timeout sets (1..65535).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 = in reset.
REQ-004 id_Rn, id_Rm  in  5 each  ID-stage source registers.
REQ-005 id_uses_Rn, id_uses_Rm, id_uses_flags  in  1 each  ID instruction reads the register or flags.
REQ-006 ex_Rn, ex_Rm  in  5 each  EX-stage source registers.
REQ-007 ex_Rd, ex_MemRead, ex_RegWrite, ex_FlagWrite  in  5/1/1/1  EX-stage destination and controls.
REQ-008 ex_branch_taken  in  1  taken branch resolved in EX.
REQ-009 mem_Rd, mem_RegWrite  in  5/1  MEM-stage destination and write enable.
REQ-010 wb_Rd, wb_RegWrite  in  5/1  WB-stage destination and write enable.
REQ-011 mem_req, mem_ack  in  1/1  data-memory request (held until ack) and acknowledge.
REQ-012 cnt_clr  in  1  synchronous clear of both counters and mem_timeout.
REQ-013 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables.
REQ-014 ifid_flush, idex_flush  out  1 each  load a bubble (all controls 0).
REQ-015 fwdA, fwdB  out  2 each  ALU operand select: 00 register file, 10 from MEM, 01 from WB.
REQ-016 stall_cnt, flush_cnt  out  16 each  saturating performance counters.
REQ-017 mem_timeout  out  1  sticky MEM_WAIT timeout error.

Function
REQ-018 FSM states RUN, MEM_WAIT; RUN->MEM_WAIT when mem_req=1 and mem_ack=0; MEM_WAIT->RUN on the cycle mem_ack=1.
REQ-019 freeze = mem_req & ~mem_ack (either state); freeze drives all five enables 0 and both flushes 0; highest priority.
REQ-020 Register 31 (XZR) never creates a hazard or forwarding match.
REQ-021 Branch (no freeze, ex_branch_taken=1): pc_en=1, ifid_flush=1, idex_flush=1, other enables 1; overrides load-use and flag stall.
REQ-022 Load-use hazard: ex_MemRead & ex_Rd!=31 & ((id_uses_Rn & id_Rn==ex_Rd) | (id_uses_Rm & id_Rm==ex_Rd)).
REQ-023 Flag hazard: ex_FlagWrite & id_uses_flags.
REQ-024 Load-use or flag hazard (no freeze, no branch): pc_en=0, ifid_en=0, idex_flush=1, idex_en/exmem_en/memwb_en=1; lasts exactly as long as the condition holds (one cycle for a single load).
REQ-025 No freeze/branch/hazard: all enables 1, flushes 0.
REQ-026 Enable/flush outputs combinational from state and current inputs; no added latency.
REQ-027 fwdA=10 if mem_RegWrite & mem_Rd!=31 & mem_Rd==ex_Rn; else 01 if wb_RegWrite & wb_Rd!=31 & wb_Rd==ex_Rn; else 00; fwdB same using ex_Rm; MEM priority over WB.
REQ-028 stall_cnt increments each cycle pc_en=0 while out of reset; flush_cnt increments each cycle of REQ-021 branch flush; both saturate at 16'hFFFF.
REQ-029 wait_cnt (internal, 16-bit) clears on entering MEM_WAIT, increments each MEM_WAIT cycle; mem_timeout sets when wait_cnt reaches TIMEOUT; cleared only by reset or cnt_clr.
REQ-030 cnt_clr same cycle as an increment: clear wins.
REQ-031 Simultaneous mem_ack and branch: freeze released, branch flush applied that cycle.

Reset
REQ-032 reset=0 asynchronously forces state RUN, counters 0, wait_cnt 0, mem_timeout 0.
REQ-033 While reset=0: all enables 0, flushes 0, fwdA/fwdB 00.
REQ-034 reset asserted mid MEM_WAIT aborts the wait; after release FSM in RUN, resumes per REQ-018 on live inputs.

Verification
REQ-035 LDUR X2 in EX (ex_MemRead=1, ex_Rd=2), ID reads id_Rn=2 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
REQ-036 Same as REQ-035 with ex_Rd=31 -> no stall, all enables 1.
REQ-037 mem_req=1, mem_ack held 0 for 3 cycles then 1 -> enables 0 for 3 cycles, 1 on ack cycle; stall_cnt=3; state returns RUN.
REQ-038 ex_branch_taken=1 with concurrent load-use -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt +1, stall_cnt unchanged.
REQ-039 mem_Rd=ex_Rn=5 and wb_Rd=5, both RegWrite=1 -> fwdA=10; mem_RegWrite=0 -> fwdA=01.
REQ-040 TIMEOUT=4, mem_ack held 0 -> mem_timeout=1 after 4 MEM_WAIT cycles, stays 1 after ack; cnt_clr=1 -> 0.
